// File: rtl/vpu_seq_control.sv
// vpu_seq_control: instruction sequencer for the VPU datapath.
//
// Fetches from a combinationally-read instruction ROM and issues datapath control words.
// Supports EXEC, WAIT, nested LOOP/ENDL, JUMP, HALT and NOP opcodes. Issue is paced by
// step (one instruction per rising edge), run (continuous while high) and halt (force
// HALTED, absorbing until fsm_rst).
//
// Instruction layout: [INSTR_WIDTH-1:DP_ADDR_WIDTH+4] flags, [DP_ADDR_WIDTH+3:DP_ADDR_WIDTH]
// opcode, [DP_ADDR_WIDTH-1:0] immediate.
//
// Ports:
//   clk, fsm_rst        clock, synchronous active-high reset
//   step, run, halt     debug/issue controls
//   rd_addr / rd_data   ROM address (= pc) and combinational read data
//   bp_en, bp_addr      breakpoint controls (only with VPU_SEQ_BREAKPOINT_EN)
//   dp_valid            one-cycle strobe qualifying dp_flags / dp_addr
//   dp_flags, dp_addr   flags and immediate of the last EXEC/WAIT issued
//   pc_out              current pc
//   curr_instr_out      last issued instruction
//   next_instr_out      instruction at pc (= rd_data)
//   state_out           IDLE=0 RUN=1 WAIT=2 HALTED=3 PAUSED=4
//   loop_level_out      loop stack occupancy
//   done, err           sticky HALT-executed / loop overflow-underflow flags
//
// Optional feature: define VPU_SEQ_BREAKPOINT_EN to enable the PC breakpoint and PAUSED state.
module vpu_seq_control #(
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned INSTR_DEPTH    = 256,
  parameter int unsigned DP_ADDR_WIDTH  = 10,
  parameter int unsigned LOOP_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = DP_ADDR_WIDTH,
  localparam int unsigned PC_WIDTH      = $clog2(INSTR_DEPTH),
  localparam int unsigned FLAG_WIDTH    = INSTR_WIDTH - DP_ADDR_WIDTH - 4,
  localparam int unsigned LVL_WIDTH     = $clog2(LOOP_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     fsm_rst,
  input  logic                     step,
  input  logic                     run,
  input  logic                     halt,
  output logic [PC_WIDTH-1:0]      rd_addr,
  input  logic [INSTR_WIDTH-1:0]   rd_data,
  input  logic                     bp_en,
  input  logic [PC_WIDTH-1:0]      bp_addr,
  output logic                     dp_valid,
  output logic [FLAG_WIDTH-1:0]    dp_flags,
  output logic [DP_ADDR_WIDTH-1:0] dp_addr,
  output logic [PC_WIDTH-1:0]      pc_out,
  output logic [INSTR_WIDTH-1:0]   curr_instr_out,
  output logic [INSTR_WIDTH-1:0]   next_instr_out,
  output logic [2:0]               state_out,
  output logic [LVL_WIDTH-1:0]     loop_level_out,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned IDX_WIDTH = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  localparam logic [3:0] OpExec = 4'd0;
  localparam logic [3:0] OpWait = 4'd1;
  localparam logic [3:0] OpLoop = 4'd2;
  localparam logic [3:0] OpEndl = 4'd3;
  localparam logic [3:0] OpJump = 4'd4;
  localparam logic [3:0] OpHalt = 4'd5;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StWait   = 3'd2,
    StHalted = 3'd3,
    StPaused = 3'd4
  } state_e;

  state_e                   state_q, state_d, issue_state;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   curr_q, curr_d;
  logic                     valid_q, valid_d;
  logic [FLAG_WIDTH-1:0]    flags_q, flags_d;
  logic [DP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PC_WIDTH-1:0]      stk_addr_q [LOOP_DEPTH];
  logic [PC_WIDTH-1:0]      stk_addr_d [LOOP_DEPTH];
  logic [CNT_WIDTH-1:0]     stk_cnt_q [LOOP_DEPTH];
  logic [CNT_WIDTH-1:0]     stk_cnt_d [LOOP_DEPTH];
  logic [LVL_WIDTH-1:0]     level_q, level_d;
  logic [CNT_WIDTH-1:0]     wait_q, wait_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     step_q;
  logic                     issue;

  logic [3:0]               opcode;
  logic [DP_ADDR_WIDTH-1:0] imm;
  logic [PC_WIDTH-1:0]      pc_inc;
  logic                     step_rise;
  logic                     stack_full, stack_empty;
  logic [IDX_WIDTH-1:0]     push_idx, top_idx;

  assign opcode      = rd_data[DP_ADDR_WIDTH+3:DP_ADDR_WIDTH];
  assign imm         = rd_data[DP_ADDR_WIDTH-1:0];
  assign pc_inc      = (pc_q == PC_WIDTH'(INSTR_DEPTH - 1)) ? '0 : pc_q + PC_WIDTH'(1);
  assign step_rise   = step & ~step_q;
  assign stack_full  = (level_q == LVL_WIDTH'(LOOP_DEPTH));
  assign stack_empty = (level_q == '0);
  assign push_idx    = IDX_WIDTH'(level_q);
  // Only read when the stack is non-empty, so the wrap at level 0 is harmless.
  assign top_idx     = IDX_WIDTH'(level_q - LVL_WIDTH'(1));

`ifdef VPU_SEQ_BREAKPOINT_EN
  logic run_q;
  logic bp_supp_q, bp_supp_d;
  logic run_rise, bp_hit;

  assign run_rise = run & ~run_q;
  // Suppression lets the instruction at the breakpoint issue once after resuming.
  assign bp_hit   = bp_en & (pc_q == bp_addr) & ~bp_supp_q;

  always_ff @(posedge clk) begin
    if (fsm_rst) begin
      run_q     <= 1'b0;
      bp_supp_q <= 1'b0;
    end else begin
      run_q     <= run;
      bp_supp_q <= bp_supp_d;
    end
  end
`else
  logic bp_unused;
  assign bp_unused = bp_en ^ (^bp_addr);
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    curr_d      = curr_q;
    valid_d     = 1'b0;
    flags_d     = flags_q;
    addr_d      = addr_q;
    stk_addr_d  = stk_addr_q;
    stk_cnt_d   = stk_cnt_q;
    level_d     = level_q;
    wait_d      = wait_q;
    done_d      = done_q;
    err_d       = err_q;
    issue       = 1'b0;
    issue_state = StIdle;
`ifdef VPU_SEQ_BREAKPOINT_EN
    bp_supp_d   = bp_supp_q;
`endif

    if (halt) begin
      state_d = StHalted;
`ifdef VPU_SEQ_BREAKPOINT_EN
      bp_supp_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_d = StRun;
          end else if (step_rise) begin
            issue       = 1'b1;
            issue_state = StIdle;
          end
        end
        StRun: begin
`ifdef VPU_SEQ_BREAKPOINT_EN
          bp_supp_d = 1'b0;
`endif
          if (!run) begin
            state_d = StIdle;
`ifdef VPU_SEQ_BREAKPOINT_EN
          end else if (bp_hit) begin
            state_d = StPaused;
`endif
          end else begin
            issue       = 1'b1;
            issue_state = StRun;
          end
        end
        StWait: begin
          // run is only looked at on the final count cycle.
          if (wait_q <= CNT_WIDTH'(1)) begin
            wait_d  = '0;
            state_d = run ? StRun : StIdle;
          end else begin
            wait_d = wait_q - CNT_WIDTH'(1);
          end
        end
        StHalted: state_d = StHalted;
`ifdef VPU_SEQ_BREAKPOINT_EN
        StPaused: begin
          if (run_rise) begin
            state_d   = StRun;
            bp_supp_d = 1'b1;
          end else if (step_rise) begin
            issue       = 1'b1;
            issue_state = StPaused;
          end
        end
`endif
        default: state_d = StHalted;
      endcase
    end

    if (issue) begin
      curr_d  = rd_data;
      state_d = issue_state;
      case (opcode)
        OpExec, OpWait: begin
          valid_d = 1'b1;
          flags_d = rd_data[INSTR_WIDTH-1:DP_ADDR_WIDTH+4];
          addr_d  = imm;
          pc_d    = pc_inc;
          if (opcode == OpWait && imm != '0) begin
            state_d = StWait;
            wait_d  = CNT_WIDTH'(imm);
          end
        end
        OpLoop: begin
          if (stack_full) begin
            err_d   = 1'b1;
            state_d = StHalted;
          end else begin
            stk_addr_d[push_idx] = pc_inc;
            stk_cnt_d[push_idx]  = (imm == '0) ? CNT_WIDTH'(1) : CNT_WIDTH'(imm);
            level_d              = level_q + LVL_WIDTH'(1);
            pc_d                 = pc_inc;
          end
        end
        OpEndl: begin
          if (stack_empty) begin
            err_d   = 1'b1;
            state_d = StHalted;
          end else if (stk_cnt_q[top_idx] > CNT_WIDTH'(1)) begin
            stk_cnt_d[top_idx] = stk_cnt_q[top_idx] - CNT_WIDTH'(1);
            pc_d               = stk_addr_q[top_idx];
          end else begin
            level_d = level_q - LVL_WIDTH'(1);
            pc_d    = pc_inc;
          end
        end
        OpJump: pc_d = imm[PC_WIDTH-1:0];
        OpHalt: begin
          done_d  = 1'b1;
          state_d = StHalted;
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fsm_rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      curr_q     <= '0;
      valid_q    <= 1'b0;
      flags_q    <= '0;
      addr_q     <= '0;
      stk_addr_q <= '{default: '0};
      stk_cnt_q  <= '{default: '0};
      level_q    <= '0;
      wait_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      curr_q     <= curr_d;
      valid_q    <= valid_d;
      flags_q    <= flags_d;
      addr_q     <= addr_d;
      stk_addr_q <= stk_addr_d;
      stk_cnt_q  <= stk_cnt_d;
      level_q    <= level_d;
      wait_q     <= wait_d;
      done_q     <= done_d;
      err_q      <= err_d;
      step_q     <= step;
    end
  end

  assign rd_addr        = pc_q;
  assign pc_out         = pc_q;
  assign dp_valid       = valid_q;
  assign dp_flags       = flags_q;
  assign dp_addr        = addr_q;
  assign curr_instr_out = curr_q;
  assign next_instr_out = rd_data;
  assign state_out      = state_q;
  assign loop_level_out = level_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: doc/vpu_seq_control.md
Name: vpu_seq_control

Overview:
Parametrised successor to the tiny instruction FSM. It fetches from the instruction ROM and issues datapath control flags to the systolic array, buffers and accumulator. Adds loop stack, WAIT, JUMP and HALT opcodes, error flags and an issue strobe. Sits between the instruction memory and the VPU datapath, driven by step/run/halt debug controls.

Parameters:
INSTR_WIDTH, 32, instruction width
INSTR_DEPTH, 256, ROM depth; PC_WIDTH = $clog2(INSTR_DEPTH)
DP_ADDR_WIDTH, 10, immediate/address field width
LOOP_DEPTH, 4, loop stack entries
CNT_WIDTH, DP_ADDR_WIDTH, loop/wait counter width

Ports:
clk  in  1  clock
fsm_rst  in  1  synchronous active-high reset
step  in  1  single-step; rising edge issues one instruction
run  in  1  level; continuous issue while high
halt  in  1  force HALTED
rd_addr  out  PC_WIDTH  ROM address, combinationally equal to pc
rd_data  in  INSTR_WIDTH  ROM data, combinational read of rd_addr
bp_en  in  1  breakpoint enable (used only with BREAKPOINT_EN)
bp_addr  in  PC_WIDTH  breakpoint PC (used only with BREAKPOINT_EN)
dp_valid  out  1  one-cycle strobe: dp_flags/dp_addr valid
dp_flags  out  INSTR_WIDTH-DP_ADDR_WIDTH-4  datapath flags, rd_data[INSTR_WIDTH-1:DP_ADDR_WIDTH+4]
dp_addr  out  DP_ADDR_WIDTH  immediate, rd_data[DP_ADDR_WIDTH-1:0]
pc_out  out  PC_WIDTH  current pc
curr_instr_out  out  INSTR_WIDTH  last issued instruction
next_instr_out  out  INSTR_WIDTH  equals rd_data (instruction at pc)
state_out  out  3  IDLE=0 RUN=1 WAIT=2 HALTED=3 PAUSED=4
loop_level_out  out  $clog2(LOOP_DEPTH+1)  stack occupancy
done  out  1  sticky; HALT opcode executed
err  out  1  sticky; loop overflow/underflow

Behaviour:
- Opcode = rd_data[DP_ADDR_WIDTH+3:DP_ADDR_WIDTH]; imm = rd_data[DP_ADDR_WIDTH-1:0].
- Reset: pc=0, state IDLE, curr_instr_out=0, dp_valid=0, dp_flags=0, dp_addr=0, stack empty, wait count 0, done=0, err=0, step_q=0.
- "Issue" at a clock edge: curr_instr_out<=rd_data, then by opcode:
  0 EXEC: dp_valid=1, dp_flags/dp_addr loaded; pc+1.
  1 WAIT: same as EXEC; if imm!=0 enter WAIT for exactly imm cycles with no issue.
  2 LOOP: push {pc+1, max(imm,1)}; pc+1; no dp_valid. Push when full: err=1, HALTED, pc unchanged.
  3 ENDL: empty stack: err=1, HALTED. Top count>1: decrement it, pc<=top addr. Else pop, pc+1.
  4 JUMP: pc<=imm[PC_WIDTH-1:0].
  5 HALT: done=1, HALTED, pc unchanged.
  6-15 NOP: pc+1.
- pc+1 wraps INSTR_DEPTH-1 -> 0.
- dp_valid is low on every non-issuing cycle. dp_flags/dp_addr hold their last value.
- Priority each edge: fsm_rst > halt > run > step.
- IDLE: run=1 -> RUN with no issue that edge. A step rise (step & ~step_q) issues one instruction; next state is IDLE, or WAIT/HALTED as the opcode dictates.
- RUN: issue every cycle while run=1. If run is sampled 0: no issue, go to IDLE.
- WAIT: decrement count each cycle. On the last cycle go to RUN if run=1, else IDLE. The run level is ignored during the count.
- halt=1 in any state: HALTED next edge, no issue.
- HALTED: absorbing until fsm_rst. Outputs hold; dp_valid=0.
- fsm_rst mid-loop or mid-wait: full reset, stack cleared.

Optional Feature:
VPU_SEQ_BREAKPOINT_EN:
- Defined: in RUN, if bp_en=1 and pc==bp_addr (and the breakpoint is not being suppressed), go to PAUSED without issuing.
- PAUSED: a step rise issues one instruction and stays PAUSED. A run rising edge goes to RUN, and the breakpoint check is suppressed for the first issue.
- Undefined: bp_en/bp_addr are ignored and state 4 is unreachable.

Test Plan:
- ROM[0..2]=EXEC flags 0x20000/0x10000/0x00800 imm 1,2,3; three step pulses -> dp_valid three single-cycle strobes, pc_out 1,2,3, curr_instr_out = ROM words.
- ROM[0]=LOOP imm 3, ROM[1]=EXEC, ROM[2]=ENDL, ROM[3]=HALT; run=1 -> exactly 3 dp_valid pulses, then state_out=3, done=1, pc_out=3.
- ROM[0]=WAIT imm 5, ROM[1]=EXEC; run=1 -> pulse, 5 cycles with state_out=2 and dp_valid=0, then pulse for ROM[1].
- 5 nested LOOPs with LOOP_DEPTH=4 -> err=1, HALTED, loop_level_out=4. A lone ENDL at reset -> err=1.
- ROM all NOP except ROM[255]=EXEC, run 256 cycles -> pc_out wraps to 0. Assert halt mid-run -> HALTED next edge. fsm_rst -> all outputs at reset values.
- With VPU_SEQ_BREAKPOINT_EN, bp_addr=4 -> PAUSED with pc_out=4. Drop run, raise run -> ROM[4] issues and the run continues.
